// File: rtl/axis_dw_pack_10_16.sv
// axis_dw_pack_10_16: AXI-Stream upsizer, packs 10-word input beats into 16-word output beats.
// Define DW_PACK_KEEP_EN to add the m_tkeep per-word valid mask.
module axis_dw_pack_10_16 #(
   parameter int DATA_WIDTH = 16,
   parameter int S_WORDS    = 10,
   parameter int M_WORDS    = 16,
   parameter int BUF_WORDS  = S_WORDS + M_WORDS
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   input  logic [S_WORDS*DATA_WIDTH-1:0] s_tdata,
   input  logic                          s_tlast,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [M_WORDS*DATA_WIDTH-1:0] m_tdata,
`ifdef DW_PACK_KEEP_EN
   output logic [M_WORDS-1:0]            m_tkeep,
`endif
   output logic                          m_tlast
);
   localparam int CW = $clog2(BUF_WORDS + 1);
   logic [DATA_WIDTH-1:0] buf_q [BUF_WORDS];
   logic [DATA_WIDTH-1:0] buf_d [BUF_WORDS];
   logic [CW-1:0] count_q, count_d;
   logic flush_q, flush_d;
   logic push, pop;
   int cnt, mcnt, popped, base;
   assign cnt      = int'(count_q);
   assign mcnt     = cnt < M_WORDS ? cnt : M_WORDS;
   assign m_tvalid = cnt >= M_WORDS || (flush_q && cnt > 0);
   assign m_tlast  = flush_q && cnt <= M_WORDS;
   assign pop      = m_tvalid && m_tready;
   // m_tready feeds s_tready: a beat leaving this cycle frees room for the incoming one
   assign s_tready = !areset && !flush_q && (cnt + S_WORDS <= BUF_WORDS + (pop ? M_WORDS : 0));
   assign push     = s_tvalid && s_tready;
   always_comb begin
      popped = pop ? mcnt : 0;
      base   = cnt - popped;
      for (int i = 0; i < BUF_WORDS; i++)
         buf_d[i] = (i + popped < BUF_WORDS) ? buf_q[CW'(i + popped)] : '0;
      if (push)
         for (int k = 0; k < S_WORDS; k++)
            if (base + k < BUF_WORDS) buf_d[CW'(base + k)] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      count_d = CW'(base + (push ? S_WORDS : 0));
      flush_d = (flush_q && !(pop && m_tlast)) || (push && s_tlast);
   end
   always_comb begin
      for (int j = 0; j < M_WORDS; j++)
         m_tdata[j*DATA_WIDTH +: DATA_WIDTH] = (j < cnt) ? buf_q[j] : '0;
   end
`ifdef DW_PACK_KEEP_EN
   always_comb begin
      for (int j = 0; j < M_WORDS; j++)
         m_tkeep[j] = m_tvalid && (j < mcnt);
   end
`endif
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         count_q <= '0;
         flush_q <= 1'b0;
      end else begin
         count_q <= count_d;
         flush_q <= flush_d;
      end
   end
   always_ff @(posedge aclk) buf_q <= buf_d;
endmodule

// File: tb/tb_axis_dw_pack_10_16.sv
// tb_axis_dw_pack_10_16: directed bench for the 10->16 word AXI-Stream packer.
module tb_axis_dw_pack_10_16;
   logic aclk, areset;
   logic s_tvalid, s_tready, s_tlast;
   logic [159:0] s_tdata;
   logic m_tvalid, m_tready, m_tlast;
   logic [255:0] m_tdata;
`ifdef DW_PACK_KEEP_EN
   logic [15:0] m_tkeep;
`endif
   int tests = 0, fails = 0;

   axis_dw_pack_10_16 dut (
      .aclk(aclk), .areset(areset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
`ifdef DW_PACK_KEEP_EN
      .m_tkeep(m_tkeep),
`endif
      .m_tlast(m_tlast)
   );

   initial aclk = 0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] exp_data(input int base, input int total, input int b);
      logic [255:0] d;
      d = '0;
      for (int j = 0; j < 16; j++)
         if (16*b + j < total) d[j*16 +: 16] = 16'(base + 16*b + j);
      return d;
   endfunction

   function automatic logic [15:0] exp_keep(input int total, input int b);
      logic [15:0] k;
      for (int j = 0; j < 16; j++) k[j] = (16*b + j < total);
      return k;
   endfunction

   // vm: 0 = source always valid, 1 = random; rm: 0 = sink always ready, 1 = random, 2 = stalled 22 cycles
   task automatic run_frame(input string tag, input int nb, input int base, input int vm, input int rm);
      int total, nout, sent, got, cyc;
      bit hold;
      logic [159:0] d;
      total = nb*10; nout = (total + 15)/16; sent = 0; got = 0; cyc = 0; hold = 0;
      while (got < nout && cyc < 3000) begin
         for (int i = 0; i < 10; i++) d[i*16 +: 16] = 16'(base + sent*10 + i);
         s_tdata  = d;
         s_tlast  = (sent == nb - 1);
         s_tvalid = (sent < nb) && (vm == 0 || $urandom_range(0, 1) == 1);
         m_tready = rm == 0 ? 1'b1 : rm == 1 ? 1'($urandom_range(0, 1)) : (cyc >= 22);
         @(negedge aclk);
         if (hold) chk({tag, "_hold"}, m_tvalid, 1);
         if (vm == 0 && rm == 0 && sent < nb) chk({tag, "_sready_cont"}, s_tready, 1);
         if (sent == nb) chk({tag, "_sready_flush"}, s_tready, 0);
         if (rm == 2 && cyc == 21) begin
            chk({tag, "_bp_sent"}, sent, 2);
            chk({tag, "_bp_sready"}, s_tready, 0);
         end
         if (m_tvalid) begin
            chk($sformatf("%s_data%0d", tag, got), m_tdata, exp_data(base, total, got));
            chk($sformatf("%s_last%0d", tag, got), m_tlast, (got + 1)*16 >= total);
`ifdef DW_PACK_KEEP_EN
            chk($sformatf("%s_keep%0d", tag, got), m_tkeep, exp_keep(total, got));
`endif
         end
         hold = m_tvalid && !m_tready;
         if (m_tvalid && m_tready) got++;
         if (s_tvalid && s_tready) sent++;
         cyc++;
         @(posedge aclk); #1;
      end
      s_tvalid = 0; s_tlast = 0;
      chk({tag, "_beats_out"}, got, nout);
      chk({tag, "_beats_in"}, sent, nb);
      @(negedge aclk);
      chk({tag, "_idle_mvalid"}, m_tvalid, 0);
      chk({tag, "_idle_sready"}, s_tready, 1);
      @(posedge aclk); #1;
   endtask

   initial begin
      areset = 1; s_tvalid = 0; s_tlast = 0; s_tdata = '0; m_tready = 0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_mlast", m_tlast, 0);
`ifdef DW_PACK_KEEP_EN
      chk("rst_keep", m_tkeep, 0);
`endif
      #2 areset = 0;
      @(posedge aclk); #1;
      chk("sready_after_rst", s_tready, 1);
      run_frame("cont", 8, 0, 0, 0);
      run_frame("partial", 3, 0, 0, 0);
      run_frame("single", 1, 0, 0, 0);
      run_frame("bp", 4, 0, 0, 2);
      for (int f = 0; f < 15; f++) run_frame("rand", 7, 70*f, 1, 1);
      m_tready = 0; s_tvalid = 1; s_tlast = 0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) s_tdata[i*16 +: 16] = 16'(500 + 10*k + i);
         @(posedge aclk); #1;
      end
      s_tvalid = 0; m_tready = 1;
      #1;
      chk("pre_rst_mvalid", m_tvalid, 1);
      chk("pre_rst_sready", s_tready, 1);
      #1 areset = 1;
      #1;
      chk("async_rst_mvalid", m_tvalid, 0);
      chk("async_rst_sready", s_tready, 0);
      @(posedge aclk);
      #3 areset = 0;
      @(posedge aclk); #1;
      run_frame("post_rst", 2, 100, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
